// File: rtl/cache_meta_ctrl.sv
// cache_meta_ctrl: 2-way set-associative metadata controller (hit/miss, shared LRU, 8-word fill); define CACHE_STATS_EN for hit/miss counters.
module cache_meta_ctrl #(
  parameter int NUM_SETS      = 64,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [15:0]               req_addr,
  output logic                      req_done,
  output logic                      req_way,
  output logic                      busy,
  output logic [2*NUM_SETS-1:0]     meta_block_en,
  output logic                      meta_write,
  output logic [7:0]                meta_data_in,
  input  logic [7:0]                meta_dout_w0,
  input  logic [7:0]                meta_dout_w1,
  output logic                      mem_rd,
  output logic [15:0]               mem_addr,
  input  logic                      mem_rvalid,
  output logic                      data_wen,
  output logic                      data_way,
  output logic [WORDS_PER_BLK-1:0]  data_word_sel
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]               stat_hits,
  output logic [15:0]               stat_misses
`endif
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = $clog2(WORDS_PER_BLK);
  localparam int EW = 2 * NUM_SETS;
  typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, FILL, INSTALL} state_t;
  state_t state;
  logic [5:0] tag;
  logic [IW-1:0] idx;
  logic hit_way, victim, retry;
  logic [WW-1:0] ret_cnt;
  logic hit0, hit1, last_ret;
  logic unused_ok;
  function automatic logic [EW-1:0] blk(input logic w, input logic [IW-1:0] i);
    return EW'(1) << (int'(i) + (w ? NUM_SETS : 0));
  endfunction
  assign hit0 = meta_dout_w0[1] && meta_dout_w0[7:2] == tag;
  assign hit1 = meta_dout_w1[1] && meta_dout_w1[7:2] == tag;
  assign last_ret = ret_cnt == WW'(WORDS_PER_BLK - 1);
  assign busy = state != IDLE;
  assign req_done = state == UPDATE && req_valid;
  assign req_way = hit_way;
  assign data_wen = state == FILL && mem_rvalid;
  assign data_way = victim;
  assign data_word_sel = data_wen ? WORDS_PER_BLK'(1) << ret_cnt : '0;
  // The LRU cell is shared by both ways, so way1's copy carries no extra information.
  assign unused_ok = ^{req_addr[3:0], meta_dout_w1[0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tag <= '0;
      idx <= '0;
      hit_way <= 1'b0;
      victim <= 1'b0;
      retry <= 1'b0;
      ret_cnt <= '0;
      meta_block_en <= '0;
      meta_write <= 1'b0;
      meta_data_in <= '0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
`ifdef CACHE_STATS_EN
      stat_hits <= '0;
      stat_misses <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          tag <= req_addr[15:10];
          idx <= req_addr[4+:IW];
          retry <= 1'b0;
          meta_block_en <= blk(1'b0, req_addr[4+:IW]) | blk(1'b1, req_addr[4+:IW]);
          state <= LOOKUP;
        end
        LOOKUP: if (hit0 || hit1) begin
          // Way0 wins if both ways (illegally) match.
          hit_way <= !hit0;
          meta_write <= 1'b1;
          meta_block_en <= blk(!hit0, idx);
          meta_data_in <= {tag, 1'b1, hit0};
          state <= UPDATE;
`ifdef CACHE_STATS_EN
          if (!retry && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
`endif
        end else begin
          victim <= meta_dout_w0[0];
          meta_block_en <= '0;
          mem_rd <= 1'b1;
          mem_addr <= {tag, idx, WW'(0), 1'b0};
          ret_cnt <= '0;
          state <= FILL;
`ifdef CACHE_STATS_EN
          if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
`endif
        end
        UPDATE: begin
          meta_write <= 1'b0;
          meta_block_en <= '0;
          state <= IDLE;
        end
        FILL: begin
          if (mem_rd) begin
            mem_rd <= mem_addr[1+:WW] != WW'(WORDS_PER_BLK - 1);
            mem_addr[1+:WW] <= mem_addr[1+:WW] + WW'(1);
          end
          if (mem_rvalid) begin
            ret_cnt <= ret_cnt + WW'(1);
            if (last_ret) begin
              meta_write <= 1'b1;
              meta_block_en <= blk(victim, idx);
              meta_data_in <= {tag, 1'b1, !victim};
              state <= INSTALL;
            end
          end
        end
        INSTALL: begin
          meta_write <= 1'b0;
          meta_block_en <= blk(1'b0, idx) | blk(1'b1, idx);
          retry <= 1'b1;
          state <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_meta_ctrl.sv
// tb_cache_meta_ctrl: directed scoreboard bench for cache_meta_ctrl with metadata-array and pipelined-memory models.
module tb_cache_meta_ctrl;
  localparam int MEM_LAT = 4;
  logic clk = 0, rst = 1, req_valid = 0;
  logic [15:0] req_addr = 0;
  logic req_done, req_way, busy, meta_write, mem_rd, mem_rvalid, data_wen, data_way;
  logic [127:0] meta_block_en;
  logic [7:0] meta_data_in, dout0, dout1, data_word_sel;
  logic [15:0] mem_addr;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif
  logic [7:0] arr0 [64];
  logic [7:0] arr1 [64];
  logic [MEM_LAT-2:0] pipe = '0;
  int cyc = 0, n_chk = 0, n_fail = 0, exp_hit = 0, exp_miss = 0;
  logic [15:0] exp_mem [$];
  logic [8:0] exp_fill [$];
  logic [14:0] exp_meta [$];
  logic exp_done_way [$];
  int exp_done_cyc [$];
  logic [14:0] me;

  cache_meta_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_done(req_done), .req_way(req_way), .busy(busy),
    .meta_block_en(meta_block_en), .meta_write(meta_write), .meta_data_in(meta_data_in),
    .meta_dout_w0(dout0), .meta_dout_w1(dout1),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .data_wen(data_wen), .data_way(data_way), .data_word_sel(data_word_sel)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns a word MEM_LAT cycles after mem_rd, counting the request cycle as the first.
  assign mem_rvalid = pipe[MEM_LAT-2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe <= {pipe[MEM_LAT-3:0], mem_rd};
  end

  always_comb begin
    dout0 = '0;
    dout1 = '0;
    for (int i = 0; i < 64; i++) begin
      if (meta_block_en[i]) dout0 = arr0[i];
      if (meta_block_en[64+i]) dout1 = arr1[i];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        arr0[i] <= '0;
        arr1[i] <= '0;
      end
    end else if (meta_write) begin
      for (int i = 0; i < 64; i++) begin
        if (meta_block_en[i]) begin
          arr0[i] <= meta_data_in;
          arr1[i][0] <= meta_data_in[0];
        end
        if (meta_block_en[64+i]) begin
          arr1[i] <= meta_data_in;
          arr0[i][0] <= meta_data_in[0];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (mem_rd) begin
      if (exp_mem.size() > 0) chk("mem_addr", 128'(mem_addr), 128'(exp_mem.pop_front()));
      else unexp("mem_rd");
    end
    if (data_wen) begin
      if (exp_fill.size() > 0) chk("fill_way_sel", 128'({data_way, data_word_sel}), 128'(exp_fill.pop_front()));
      else unexp("data_wen");
    end
    if (meta_write) begin
      if (exp_meta.size() > 0) begin
        me = exp_meta.pop_front();
        chk("meta_block_en", meta_block_en, 128'(1) << me[14:8]);
        chk("meta_data_in", 128'(meta_data_in), 128'(me[7:0]));
      end else unexp("meta_write");
    end
    if (req_done) begin
      if (exp_done_way.size() > 0) begin
        chk("req_way", 128'(req_way), 128'(exp_done_way.pop_front()));
        chk("done_cycle", 128'(cyc), 128'(exp_done_cyc.pop_front()));
      end else unexp("req_done");
    end
  end

  task automatic access(input logic [15:0] a, input bit miss, input bit way, input logic [7:0] md, input bit drop);
    int k;
    bit fin;
    logic [6:0] bi;
    bi = {way, a[9:4]};
    if (miss) begin
      for (int w = 0; w < 8; w++) begin
        exp_mem.push_back({a[15:4], w[2:0], 1'b0});
        exp_fill.push_back({way, 8'(1 << w)});
      end
      exp_meta.push_back({bi, md});
      exp_miss++;
    end else exp_hit++;
    exp_meta.push_back({bi, md});
    @(negedge clk);
    req_valid = 1;
    req_addr = a;
    k = cyc;
    fin = 0;
    if (!drop) begin
      exp_done_way.push_back(way);
      exp_done_cyc.push_back(k + (miss ? 15 : 2));
    end
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (drop) begin
        if (cyc == k + 5) req_valid = 0;
        if (cyc == k + 15) chk("busy_in_update", 128'(busy), 128'(1));
        if (cyc == k + 16) begin
          chk("busy_after_update", 128'(busy), 128'(0));
          fin = 1;
        end
      end else if (req_done) begin
        #1 req_valid = 0;
        fin = 1;
      end
    end
    chk("access_complete", 128'(fin), 128'(1));
  endtask

  task automatic reset_mid_fill(input logic [15:0] a);
    int cnt;
    bit fin;
    for (int w = 0; w < 6; w++) exp_mem.push_back({a[15:4], w[2:0], 1'b0});
    for (int w = 0; w < 3; w++) exp_fill.push_back({1'b0, 8'(1 << w)});
    @(negedge clk);
    req_valid = 1;
    req_addr = a;
    cnt = 0;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (mem_rvalid) cnt++;
      if (cnt == 3) begin
        #1 rst = 1;
        req_valid = 0;
        fin = 1;
      end
    end
    chk("rst_at_third_return", 128'(fin), 128'(1));
    @(negedge clk);
    chk("rst_block_en", meta_block_en, 128'(0));
    chk("rst_outputs", 128'({busy, req_done, req_way, meta_write, meta_data_in, mem_rd, mem_addr,
                             data_wen, data_way, data_word_sel}), 128'(0));
    rst = 0;
    exp_hit = 0;
    exp_miss = 0;
    repeat (5) @(negedge clk);
    chk("abort_pending", 128'(exp_mem.size() + exp_fill.size() + exp_meta.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_block_en", meta_block_en, 128'(0));
    chk("reset_outputs", 128'({req_done, meta_write, meta_data_in, mem_rd, mem_addr, data_wen, data_word_sel}), 128'(0));
    rst = 0;
    access(16'h0410, 1, 0, 8'h07, 0);
    access(16'h0412, 0, 0, 8'h07, 0);
    access(16'h0810, 1, 1, 8'h0A, 0);
    access(16'h0C10, 1, 0, 8'h0F, 0);
    access(16'h0814, 0, 1, 8'h0A, 0);
    access(16'hFFF0, 1, 0, 8'hFF, 0);
    access(16'hFBF0, 1, 1, 8'hFA, 0);
    reset_mid_fill(16'h1420);
    access(16'h1420, 1, 0, 8'h17, 0);
    access(16'h2830, 1, 0, 8'h2B, 1);
    access(16'h2832, 0, 0, 8'h2B, 0);
    access(16'h283E, 0, 0, 8'h2B, 0);
    access(16'h2834, 0, 0, 8'h2B, 0);
    repeat (8) @(negedge clk);
    chk("left_mem", 128'(exp_mem.size()), 128'(0));
    chk("left_fill", 128'(exp_fill.size()), 128'(0));
    chk("left_meta", 128'(exp_meta.size()), 128'(0));
    chk("left_done", 128'(exp_done_way.size()), 128'(0));
`ifdef CACHE_STATS_EN
    chk("stat_hits", 128'(stat_hits), 128'(exp_hit));
    chk("stat_misses", 128'(stat_misses), 128'(exp_miss));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
